// File: rtl/md_alu.sv
// Execute-stage ALU (combinational, zero latency) plus a multi-cycle mult/div unit owning HI/LO.
// MUL_LAT/DIV_LAT cycles of Busy per op; starts while Busy are dropped, and the hazard unit stalls on Busy.
module md_alu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic [2:0]       MDOp,
  input  logic             MDStart,
  output logic [WIDTH-1:0] Result,
  output logic             ZF,
  output logic             OV,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int SHW     = $clog2(WIDTH);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  // ---------------- combinational ALU ----------------
  logic [WIDTH-1:0] sum, diff;
  logic [SHW-1:0]   shamt;

  assign sum   = A + B;
  assign diff  = A - B;
  assign shamt = B[SHW-1:0];

  always_comb begin
    Result = '0;
    OV     = 1'b0;
    case (ALUOp)
      4'd0: begin
        Result = sum;
        OV     = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        Result = diff;
        OV     = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'd2:    Result = A | B;
      4'd3:    Result = B << (WIDTH / 2);
      4'd4:    Result = A & B;
      4'd5:    Result = A ^ B;
      4'd6:    Result = ~(A | B);
      4'd7:    Result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd8:    Result = {{(WIDTH-1){1'b0}}, (A < B)};
      4'd9:    Result = A << shamt;
      4'd10:   Result = A >> shamt;
      4'd11:   Result = $signed(A) >>> shamt;
      default: Result = '0;
    endcase
  end

  assign ZF = (Result == '0);

  // ---------------- multiply / divide ----------------
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             busy_q;

  logic               signed_op, is_mul, a_neg, b_neg;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   a_mag, b_mag, uq, ur, quo, rem;

  assign signed_op = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign is_mul    = (op_q == MD_MULT) || (op_q == MD_MULTU);

  // Low 2*WIDTH bits of the extended product are exact for both signednesses.
  assign a_ext = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = a_ext * b_ext;

  // Signed divide on magnitudes; most-negative / -1 falls out as most-negative, remainder 0.
  assign a_neg = signed_op && a_q[WIDTH-1];
  assign b_neg = signed_op && b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  assign uq    = a_mag / b_mag;
  assign ur    = a_mag % b_mag;
  assign quo   = (a_neg ^ b_neg) ? -uq : uq;
  assign rem   = a_neg ? -ur : ur;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MDStart) begin
            case (MDOp)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                op_q   <= MDOp;
                a_q    <= A;
                b_q    <= B;
                cnt    <= ((MDOp == MD_MULT) || (MDOp == MD_MULTU)) ? CW'(MUL_LAT) : CW'(DIV_LAT);
                busy_q <= 1'b1;
                state  <= RUN;
              end
              MD_MTHI: hi_q <= A;
              MD_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy_q <= 1'b0;
            state  <= IDLE;
            if (is_mul) begin
              {hi_q, lo_q} <= prod;
            end else if (b_q != '0) begin
              hi_q <= rem;
              lo_q <= quo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_alu.sv
// Randomised scoreboard bench for md_alu: driver pushes expectations, negedge monitor pops and compares.
module tb_md_alu;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  A, B;
  logic [3:0]    ALUOp;
  logic [2:0]    MDOp;
  logic          MDStart;
  logic [W-1:0]  Result, HI, LO;
  logic          ZF, OV, Busy;

  always #5 clk = ~clk;

  md_alu #(.WIDTH(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .ALUOp(ALUOp), .MDOp(MDOp),
    .MDStart(MDStart), .Result(Result), .ZF(ZF), .OV(OV), .Busy(Busy), .HI(HI), .LO(LO)
  );

  typedef struct { logic [31:0] hi; logic [31:0] lo; int lat; } md_exp_t;
  typedef struct { logic [31:0] res; logic zf; logic ov; } alu_exp_t;

  md_exp_t  md_q[$];
  alu_exp_t alu_q[$];
  md_exp_t  me;
  alu_exp_t ae;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] vis_hi = '0;
  logic [31:0] vis_lo = '0;
  int          free_edge = 0;
  logic        prev_busy = 1'b0;
  int          busy_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the operation definitions, in 64-bit arithmetic.
  function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    logic [63:0] sv;
    r  = '0;
    ov = 1'b0;
    case (op)
      4'd0: begin s = sa + sb; sv = s; r = sv[31:0]; ov = (s > SMAX) || (s < SMIN); end
      4'd1: begin s = sa - sb; sv = s; r = sv[31:0]; ov = (s > SMAX) || (s < SMIN); end
      4'd2:  r = a | b;
      4'd3:  r = {b[15:0], 16'h0000};
      4'd4:  r = a & b;
      4'd5:  r = a ^ b;
      4'd6:  r = ~(a | b);
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  r = (a < b) ? 32'd1 : 32'd0;
      4'd9:  r = a << b[4:0];
      4'd10: r = a >> b[4:0];
      4'd11: r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
  endfunction

  // Reference HI/LO after an op, starting from the currently visible values.
  function automatic void md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = a;
    longint unsigned ub = b;
    logic [63:0]     p;
    hi = vis_hi;
    lo = vis_lo;
    case (op)
      3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
      3'd3: if (b != 0) begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
      3'd4: if (b != 0) begin p = ua / ub; lo = p[31:0]; p = ua % ub; hi = p[31:0]; end
      default: ;
    endcase
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (alu_q.size() > 0) begin
        ae = alu_q.pop_front();
        chk("alu_result", Result, ae.res);
        chk("alu_zf", ZF, ae.zf);
        chk("alu_ov", OV, ae.ov);
      end
      if (Busy) begin
        if (!prev_busy && md_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL busy_unexpected: got Busy=1 expected 0 at %0t", $time);
        end
        busy_cnt++;
        chk("hold_hi", HI, vis_hi);
        chk("hold_lo", LO, vis_lo);
      end else if (prev_busy) begin
        if (md_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL commit_unexpected: got HI=%h LO=%h expected no commit", HI, LO);
        end else begin
          me = md_q.pop_front();
          chk("busy_cycles", busy_cnt, me.lat);
          chk("commit_hi", HI, me.hi);
          chk("commit_lo", LO, me.lo);
          vis_hi = me.hi;
          vis_lo = me.lo;
        end
        busy_cnt = 0;
      end else begin
        chk("idle_hi", HI, vis_hi);
        chk("idle_lo", LO, vis_lo);
      end
      prev_busy = Busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_chk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_exp_t    e;
    logic [31:0] r;
    logic        ov;
    ALUOp = op;
    A     = a;
    B     = b;
    alu_ref(op, a, b, r, ov);
    e.res = r;
    e.ov  = ov;
    e.zf  = (r == 0);
    alu_q.push_back(e);
    tick();
  endtask

  task automatic md_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          edge_n;
    md_exp_t     e;
    logic [31:0] hi, lo;
    MDStart = 1'b1;
    MDOp    = op;
    A       = a;
    B       = b;
    tick();
    edge_n  = int'($time / 10);
    MDStart = 1'b0;
    if (edge_n >= free_edge) begin
      case (op)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          md_ref(op, a, b, hi, lo);
          e.hi  = hi;
          e.lo  = lo;
          e.lat = (op <= 3'd2) ? MUL_LAT : DIV_LAT;
          md_q.push_back(e);
          free_edge = edge_n + e.lat + 1;
        end
        3'd5: vis_hi = a;
        3'd6: vis_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic rand_alu(input int n);
    for (int i = 0; i < n; i++)
      alu_chk(4'($urandom_range(0, 15)), $urandom, $urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    MDStart = 1'b0;
    MDOp    = '0;
    ALUOp   = '0;
    A       = '0;
    B       = '0;
    #1;
    chk("reset_busy", Busy, 0);
    chk("reset_hi", HI, 0);
    chk("reset_lo", LO, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Combinational ALU corners
    alu_chk(4'd0, 32'h7FFF_FFFF, 32'h1);
    alu_chk(4'd1, 32'd5, 32'd5);
    alu_chk(4'd1, 32'h8000_0000, 32'h1);
    alu_chk(4'd3, 32'h0, 32'h1234);
    alu_chk(4'd11, 32'h8000_0000, 32'd4);
    alu_chk(4'd7, 32'hFFFF_FFFF, 32'd1);
    alu_chk(4'd8, 32'hFFFF_FFFF, 32'd1);
    alu_chk(4'd9, 32'h1, 32'd35);
    alu_chk(4'd10, 32'h8000_0000, 32'd31);
    alu_chk(4'd6, 32'h0, 32'h0);
    alu_chk(4'd12, 32'h1, 32'h2);
    alu_chk(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // mult with mthi and divu attempted while busy
    md_issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    tick();
    md_issue(3'd5, 32'hAA, 32'd0);
    md_issue(3'd4, 32'd9, 32'd4);
    repeat (MUL_LAT + 1) tick();

    md_issue(3'd4, 32'd7, 32'd2);
    rand_alu(DIV_LAT + 1);
    md_issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    repeat (DIV_LAT + 1) tick();
    md_issue(3'd3, 32'd123, 32'd0);
    repeat (DIV_LAT + 1) tick();
    md_issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (DIV_LAT + 1) tick();

    md_issue(3'd5, 32'h55, 32'd0);
    md_issue(3'd6, 32'h66, 32'd0);
    tick();

    // Restart at the falling edge is dropped, one edge later is taken
    md_issue(3'd2, 32'hDEAD_BEEF, 32'h1000_0001);
    repeat (MUL_LAT - 1) tick();
    md_issue(3'd1, 32'd5, 32'd6);
    md_issue(3'd4, 32'd100, 32'd7);
    rand_alu(DIV_LAT + 1);

    // Asynchronous reset in the middle of a divide
    md_issue(3'd6, 32'h1357, 32'd0);
    md_issue(3'd3, 32'd1000, 32'd7);
    repeat (4) tick();
    reset_n = 1'b0;
    md_q.delete();
    vis_hi    = '0;
    vis_lo    = '0;
    free_edge = 0;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (DIV_LAT + 5) tick();

    // Random mix of ALU traffic and md starts, some landing while busy
    for (int it = 0; it < 150; it++) begin
      logic [31:0] a, b;
      int          sel;
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 3) != 0) md_issue(3'($urandom_range(0, 7)), a, b);
      rand_alu($urandom_range(0, 12));
    end

    for (int i = 0; i < 40 && (md_q.size() != 0 || Busy); i++) tick();
    if (md_q.size() != 0 || Busy) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", md_q.size());
    end
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
